// File: rtl/id_rn_buffer.sv
// id_rn_buffer: decoupling FIFO between the decode and rename stages.
//
// Holds up to DEPTH decoded-instruction bundles in a circular buffer. Decode pushes
// with a valid/ready handshake and rename pops the head with a valid/ready handshake.
// A flush discards everything in one cycle. EN low freezes all state.
//
// Ports:
//   clk          sole clock, all state updates on its rising edge
//   rst          synchronous active-low reset
//   EN           global enable; low holds all state and drops in_ready/out_valid
//   flush        discard all buffered entries
//   in_valid     decode presents a bundle on in_payload
//   in_payload   bundle from decode
//   in_ready     buffer accepts a bundle this cycle
//   out_valid    head bundle available to rename
//   out_payload  head bundle (zero when empty)
//   out_ready    rename consumes the head this cycle
//   count        current occupancy
//   almost_full  count >= AF_LEVEL
//   flush_cnt    saturating count of flush cycles that discarded at least one entry
module id_rn_buffer #(
  parameter int unsigned PAYLOAD_W = 96,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AF_LEVEL  = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       EN,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [PAYLOAD_W-1:0]       in_payload,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [PAYLOAD_W-1:0]       out_payload,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full,
  output logic [7:0]                 flush_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PAYLOAD_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [7:0]           flush_cnt_q, flush_cnt_d;

  logic empty, full, push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));

  // in_ready deliberately ignores out_ready: a full buffer never accepts in the
  // same cycle it pops, which keeps the ready path free of the rename stall.
  assign in_ready    = EN & ~flush & ~full;
  assign out_valid   = EN & ~empty;
  assign out_payload = empty ? '0 : mem_q[rd_ptr_q];
  assign count       = count_q;
  assign almost_full = (count_q >= CntW'(AF_LEVEL));
  assign flush_cnt   = flush_cnt_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    flush_cnt_d = flush_cnt_q;
    if (EN) begin
      if (flush) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
        if (!empty && flush_cnt_q != 8'hFF) begin
          flush_cnt_d = flush_cnt_q + 8'd1;
        end
      end else begin
        if (push) begin
          wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
          rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
          2'b10:   count_d = count_q + CntW'(1);
          2'b01:   count_d = count_q - CntW'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      flush_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Entry storage is not reset; stale data is never visible because out_payload is
  // masked while empty and every slot is rewritten before the read pointer reaches it.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_q[wr_ptr_q] <= in_payload;
    end
  end

endmodule
